dma_ci_controller: RTL and testbench
====================================

Name: dma_ci_controller

Overview:
Custom-instruction DMA engine. Owns a 512x32 dual-port scratch SRAM: the CPU reaches port A via CI, the DMA bus-master FSM uses port B. Moves blocks between SRAM and the system bus in bursts, programmed entirely through CI register writes.

Parameters:
CUSTOM_ID, 8'h00, ciN value this block responds to
MEM_ADDR_W, 9, SRAM word-address width (depth 2**MEM_ADDR_W)

Ports:
clock  in  1  system clock
reset  in  1  reset, synchronous, active-high
start  in  1  CI start strobe
valueA  in  32  CI operand A: command/address
valueB  in  32  CI operand B: write data
ciN  in  8  CI number
result  out  32  CI read data, valid while done=1
done  out  1  CI completion, one-cycle pulse
bus_request  out  1  bus arbitration request
bus_grant  in  1  bus grant
bus_begin  out  1  transaction start, one-cycle pulse
bus_address  out  32  byte address of burst, valid with bus_begin
bus_read_n_write  out  1  1=read from bus, valid with bus_begin
bus_burst_size  out  8  words in burst minus 1, valid with bus_begin
bus_data_in  in  32  read data from slave
bus_data_valid_in  in  1  bus_data_in valid
bus_data_out  out  32  write data to slave
bus_data_valid_out  out  1  bus_data_out valid
bus_busy  in  1  slave stall; hold write data while high
bus_end_out  out  1  end of write burst, one-cycle pulse
bus_error  in  1  slave error, aborts transfer

Behaviour:
- CI decode only when start=1, ciN==CUSTOM_ID, valueA[31:13]==0; else ignored, no done. valueA[12:10]=register select, valueA[9]=write, valueA[8:0]=SRAM address (reg 0 only).
- Registers: 0 SRAM data; 1 bus start addr (32b, [1:0] forced 0); 2 SRAM start addr (9b); 3 block size in words (10b, 0..512); 4 burst size minus 1 (8b); 5 control/status; 6-7 read 0, writes ignored.
- Config reg write/read: done pulse 1 cycle after start; result = register zero-extended. SRAM write: done 1 cycle after start. SRAM read: done 2 cycles after start. Further starts while a CI op is pending are ignored.
- Control write: bit0=1 start bus->SRAM, else bit1=1 start SRAM->bus; bit0 wins if both. Status read: bit0 busy, bit1 error, others 0. Writes to regs 1-5 while busy ignored (done still pulses). Start clears error.
- FSM: IDLE -> REQ (bus_request=1 until bus_grant) -> BEGIN (1 cycle; burst = min(burst+1, remaining)) -> RD_DATA or WR_DATA -> NEXT -> REQ if remaining>0, else IDLE. bus_request held through burst, dropped in NEXT.
- RD_DATA: each cycle with bus_data_valid_in writes port B at SRAM addr, addr+1, remaining-1; after burst count, go NEXT.
- WR_DATA: port-B prefetch (1-cycle latency) so bus_data_valid_out high from cycle after BEGIN; word advances only when bus_busy=0; after last word accepted, bus_end_out pulse, go NEXT.
- Addressing: bus addr += 4 per word; SRAM addr wraps modulo 512.
- Block size 0 at start: no bus activity; busy stays 0.
- bus_error in any non-IDLE state: drop all bus outputs next cycle, error=1, go IDLE.
- CI port A and DMA port B may hit same word same cycle: port-A write wins; read returns old data.
- Reset: all outputs 0, FSM IDLE, registers 0; SRAM contents not cleared. Reset mid-burst drops bus_request next edge.

Optional Feature:
DMA_CI_IRQ_EN: adds output irq (1b): set on transfer completion or error, cleared by CI status read or reset. Without macro: no irq port; software polls status.

Decomposition:
Package dma_ci_pkg: register-select localparams, control/status bit positions, FSM state enum. Sub-module dma_dual_port_ram (true dual-port, registered reads, write-first irrelevant per rule above).

Test Plan:
- CI write 0xDEADBEEF to SRAM 0x1F3, read back -> done at +1 and +2 cycles, result 0xDEADBEEF.
- bus 0x1000, SRAM 0, size 8, burst 3 (4 words), control=1 -> two bursts at 0x1000, 0x1010, bus_burst_size=3; SRAM[0..7] = slave data; status busy 1 -> 0.
- SRAM->bus, size 5, burst 3, bus_busy high 2 cycles mid-burst -> bursts 4 then 1 words, data held during busy, bus_end_out after each.
- SRAM start 510, size 4, read -> writes SRAM 510, 511, 0, 1.
- bus_error on word 2 -> bus_request low next cycle, status=0x2; next start clears error.
- Reset asserted mid-burst -> bus_request, bus_begin, done 0 next cycle; status reads 0.

Source files
------------

// File: rtl/dma_ci_pkg.sv
// Shared definitions for the custom-instruction DMA engine: CI command layout,
// register map, control/status bit positions and DMA FSM states.
package dma_ci_pkg;

    localparam int unsigned CI_DATA_W = 32;

    localparam logic [2:0] REG_SRAM_DATA = 3'd0;
    localparam logic [2:0] REG_BUS_ADDR  = 3'd1;
    localparam logic [2:0] REG_SRAM_ADDR = 3'd2;
    localparam logic [2:0] REG_BLK_SIZE  = 3'd3;
    localparam logic [2:0] REG_BURST_M1  = 3'd4;
    localparam logic [2:0] REG_CTRL      = 3'd5;

    localparam int unsigned CTRL_BUS_TO_SRAM = 0;
    localparam int unsigned CTRL_SRAM_TO_BUS = 1;
    localparam int unsigned STAT_BUSY        = 0;
    localparam int unsigned STAT_ERROR       = 1;

    // Layout of CI operand A
    typedef struct packed {
        logic [18:0] zero;
        logic [2:0]  sel;
        logic        wr;
        logic [8:0]  addr;
    } ci_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_BEGIN,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_NEXT
    } dma_state_e;

endpackage

// File: rtl/dma_dual_port_ram.sv
// True dual-port scratch SRAM with registered reads. On a same-address write
// collision port A wins; reads always return the pre-write contents.
module dma_dual_port_ram #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Port A write is issued last so it overrides port B on a collision
    always_ff @(posedge clock) begin
        rdata_a <= mem[addr_a];
        rdata_b <= mem[addr_b];
        if (we_b) mem[addr_b] <= wdata_b;
        if (we_a) mem[addr_a] <= wdata_a;
    end

endmodule

// File: rtl/dma_ci_controller.sv
// Custom-instruction DMA engine: CI register file and SRAM port A, plus a bus
// master moving bursts between SRAM port B and the system bus. DMA_CI_IRQ_EN adds irq.
module dma_ci_controller
    import dma_ci_pkg::*;
#(
    parameter logic [7:0]  CUSTOM_ID  = 8'h00,
    parameter int unsigned MEM_ADDR_W = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic [7:0]  ciN,
    output logic [31:0] result,
    output logic        done,
    output logic        bus_request,
    input  logic        bus_grant,
    output logic        bus_begin,
    output logic [31:0] bus_address,
    output logic        bus_read_n_write,
    output logic [7:0]  bus_burst_size,
    input  logic [31:0] bus_data_in,
    input  logic        bus_data_valid_in,
    output logic [31:0] bus_data_out,
    output logic        bus_data_valid_out,
    input  logic        bus_busy,
    output logic        bus_end_out,
`ifdef DMA_CI_IRQ_EN
    output logic        irq,
`endif
    input  logic        bus_error
);

    localparam int unsigned SIZE_W  = MEM_ADDR_W + 1;
    localparam int unsigned BURST_W = 8;
    localparam int unsigned LEN_W   = BURST_W + 1;

    ci_cmd_t                 cmd;
    logic                    ci_hit_c;
    logic                    rd_pend;
    logic [CI_DATA_W-1:0]    reg_rdata_c;
    logic                    busy_c;
    logic                    start_xfer_c;
    logic                    status_rd_c;

    logic [31:0]             bus_addr_reg;
    logic [MEM_ADDR_W-1:0]   sram_start;
    logic [SIZE_W-1:0]       block_size;
    logic [BURST_W-1:0]      burst_m1;
    logic                    error;

    dma_state_e              state, state_nxt;
    logic                    is_read;
    logic [31:0]             cur_bus;
    logic [MEM_ADDR_W-1:0]   cur_sram;
    logic [MEM_ADDR_W-1:0]   sram_nxt_c;
    logic [SIZE_W-1:0]       remaining;
    logic [BURST_W-1:0]      word_cnt;
    logic [LEN_W-1:0]        burst_len;
    logic [SIZE_W-1:0]       burst_full_c;
    logic [LEN_W-1:0]        burst_len_c;
    logic                    last_c;
    logic                    word_acc_c;

    logic                    we_a_c, we_b_c;
    logic [MEM_ADDR_W-1:0]   addr_b_c;
    logic [31:0]             rdata_a, rdata_b;

    assign cmd          = ci_cmd_t'(valueA);
    assign ci_hit_c     = start && (ciN == CUSTOM_ID) && (cmd.zero == '0) && !rd_pend;
    assign busy_c       = (state != ST_IDLE);
    assign start_xfer_c = ci_hit_c && cmd.wr && (cmd.sel == REG_CTRL) && !busy_c &&
                          (valueB[CTRL_BUS_TO_SRAM] || valueB[CTRL_SRAM_TO_BUS]);
    assign status_rd_c  = ci_hit_c && !cmd.wr && (cmd.sel == REG_CTRL);
    assign we_a_c       = ci_hit_c && cmd.wr && (cmd.sel == REG_SRAM_DATA);

    dma_dual_port_ram #(
        .ADDR_W (MEM_ADDR_W),
        .DATA_W (32)
    ) u_ram (
        .clock   (clock),
        .we_a    (we_a_c),
        .addr_a  (MEM_ADDR_W'(cmd.addr)),
        .wdata_a (valueB),
        .rdata_a (rdata_a),
        .we_b    (we_b_c),
        .addr_b  (addr_b_c),
        .wdata_b (bus_data_in),
        .rdata_b (rdata_b)
    );

    always_comb begin
        reg_rdata_c = '0;
        case (cmd.sel)
            REG_BUS_ADDR:  reg_rdata_c = bus_addr_reg;
            REG_SRAM_ADDR: reg_rdata_c = CI_DATA_W'(sram_start);
            REG_BLK_SIZE:  reg_rdata_c = CI_DATA_W'(block_size);
            REG_BURST_M1:  reg_rdata_c = CI_DATA_W'(burst_m1);
            REG_CTRL: begin
                reg_rdata_c[STAT_BUSY]  = busy_c;
                reg_rdata_c[STAT_ERROR] = error;
            end
            default:       reg_rdata_c = '0;
        endcase
    end

    // CI side: config registers, done/result, SRAM read pipeline
    always_ff @(posedge clock) begin
        if (reset) begin
            done         <= 1'b0;
            result       <= '0;
            rd_pend      <= 1'b0;
            bus_addr_reg <= '0;
            sram_start   <= '0;
            block_size   <= '0;
            burst_m1     <= '0;
        end else begin
            done    <= 1'b0;
            result  <= '0;
            rd_pend <= 1'b0;
            if (rd_pend) begin
                done   <= 1'b1;
                result <= rdata_a;
            end else if (ci_hit_c) begin
                if (cmd.sel == REG_SRAM_DATA && !cmd.wr) begin
                    rd_pend <= 1'b1;
                end else begin
                    done <= 1'b1;
                    if (!cmd.wr) result <= reg_rdata_c;
                end
                if (cmd.wr && !busy_c) begin
                    case (cmd.sel)
                        REG_BUS_ADDR:  bus_addr_reg <= {valueB[31:2], 2'b00};
                        REG_SRAM_ADDR: sram_start   <= MEM_ADDR_W'(valueB);
                        REG_BLK_SIZE:  block_size   <= SIZE_W'(valueB);
                        REG_BURST_M1:  burst_m1     <= BURST_W'(valueB);
                        default:       ;
                    endcase
                end
            end
        end
    end

    assign burst_full_c = SIZE_W'(burst_m1) + SIZE_W'(1);
    assign burst_len_c  = (burst_full_c < remaining) ? LEN_W'(burst_full_c) : LEN_W'(remaining);
    assign last_c       = (LEN_W'(word_cnt) == (burst_len - LEN_W'(1)));

    always_comb begin
        state_nxt  = state;
        word_acc_c = 1'b0;
        unique case (state)
            ST_IDLE:    if (start_xfer_c && (block_size != '0)) state_nxt = ST_REQ;
            ST_REQ:     if (bus_grant) state_nxt = ST_BEGIN;
            ST_BEGIN:   state_nxt = is_read ? ST_RD_DATA : ST_WR_DATA;
            ST_RD_DATA: if (bus_data_valid_in) begin
                            word_acc_c = 1'b1;
                            if (last_c) state_nxt = ST_NEXT;
                        end
            ST_WR_DATA: if (!bus_busy) begin
                            word_acc_c = 1'b1;
                            if (last_c) state_nxt = ST_NEXT;
                        end
            ST_NEXT:    state_nxt = (remaining != '0) ? ST_REQ : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (busy_c && bus_error) begin
            state_nxt  = ST_IDLE;
            word_acc_c = 1'b0;
        end
    end

    // Write reads use the post-advance address so port B prefetches the next word
    assign sram_nxt_c = word_acc_c ? (cur_sram + MEM_ADDR_W'(1)) : cur_sram;
    assign addr_b_c   = (state == ST_RD_DATA) ? cur_sram : sram_nxt_c;
    assign we_b_c     = word_acc_c && (state == ST_RD_DATA);

    assign bus_data_out = bus_data_valid_out ? rdata_b : '0;

    // DMA state, working counters and registered bus outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= ST_IDLE;
            error              <= 1'b0;
            is_read            <= 1'b0;
            cur_bus            <= '0;
            cur_sram           <= '0;
            remaining          <= '0;
            word_cnt           <= '0;
            burst_len          <= '0;
            bus_request        <= 1'b0;
            bus_begin          <= 1'b0;
            bus_address        <= '0;
            bus_read_n_write   <= 1'b0;
            bus_burst_size     <= '0;
            bus_data_valid_out <= 1'b0;
            bus_end_out        <= 1'b0;
        end else begin
            state              <= state_nxt;
            bus_request        <= (state_nxt == ST_REQ) || (state_nxt == ST_BEGIN) ||
                                  (state_nxt == ST_RD_DATA) || (state_nxt == ST_WR_DATA);
            bus_begin          <= (state_nxt == ST_BEGIN);
            bus_address        <= (state_nxt == ST_BEGIN) ? cur_bus : '0;
            bus_read_n_write   <= (state_nxt == ST_BEGIN) && is_read;
            bus_burst_size     <= (state_nxt == ST_BEGIN) ? BURST_W'(burst_len_c - LEN_W'(1)) : '0;
            bus_data_valid_out <= (state_nxt == ST_WR_DATA);
            bus_end_out        <= (state == ST_WR_DATA) && (state_nxt == ST_NEXT);

            if (start_xfer_c) begin
                error     <= 1'b0;
                is_read   <= valueB[CTRL_BUS_TO_SRAM];
                cur_bus   <= bus_addr_reg;
                cur_sram  <= sram_start;
                remaining <= block_size;
            end
            if (state_nxt == ST_BEGIN) burst_len <= burst_len_c;
            if (state == ST_BEGIN) begin
                word_cnt <= '0;
            end else if (word_acc_c) begin
                word_cnt  <= word_cnt + BURST_W'(1);
                cur_sram  <= sram_nxt_c;
                cur_bus   <= cur_bus + 32'd4;
                remaining <= remaining - SIZE_W'(1);
            end
            if (busy_c && bus_error) error <= 1'b1;
        end
    end

`ifdef DMA_CI_IRQ_EN
    // Completion or error raises irq; a status read acknowledges it
    always_ff @(posedge clock) begin
        if (reset) begin
            irq <= 1'b0;
        end else if ((state == ST_NEXT && state_nxt == ST_IDLE) || (busy_c && bus_error)) begin
            irq <= 1'b1;
        end else if (status_rd_c) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_dma_ci_controller.sv
// Directed bench for dma_ci_controller: CI register/SRAM access and bus bursts
// driven by a small in-line bus slave, with hand-computed expectations.
module tb_dma_ci_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] valueA, valueB;
    logic [7:0]  ciN;
    logic [31:0] result;
    logic        done;
    logic        bus_request, bus_grant, bus_begin, bus_read_n_write;
    logic [31:0] bus_address;
    logic [7:0]  bus_burst_size;
    logic [31:0] bus_data_in, bus_data_out;
    logic        bus_data_valid_in, bus_data_valid_out;
    logic        bus_busy, bus_end_out, bus_error;
`ifdef DMA_CI_IRQ_EN
    logic        irq;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    dma_ci_controller #(.CUSTOM_ID(8'h00), .MEM_ADDR_W(9)) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .valueA             (valueA),
        .valueB             (valueB),
        .ciN                (ciN),
        .result             (result),
        .done               (done),
        .bus_request        (bus_request),
        .bus_grant          (bus_grant),
        .bus_begin          (bus_begin),
        .bus_address        (bus_address),
        .bus_read_n_write   (bus_read_n_write),
        .bus_burst_size     (bus_burst_size),
        .bus_data_in        (bus_data_in),
        .bus_data_valid_in  (bus_data_valid_in),
        .bus_data_out       (bus_data_out),
        .bus_data_valid_out (bus_data_valid_out),
        .bus_busy           (bus_busy),
        .bus_end_out        (bus_end_out),
`ifdef DMA_CI_IRQ_EN
        .irq                (irq),
`endif
        .bus_error          (bus_error)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cmd(input int sel, input bit wr, input int addr);
        return {19'b0, 3'(sel), wr, 9'(addr)};
    endfunction

    task automatic ci_write(input int sel, input int addr, input logic [31:0] data);
        start = 1'b1; ciN = 8'h00; valueA = cmd(sel, 1'b1, addr); valueB = data;
        tick();
        start = 1'b0;
        check($sformatf("wr_done_r%0d", sel), done, 1);
    endtask

    task automatic ci_read(input int sel, input int addr, output logic [31:0] data);
        start = 1'b1; ciN = 8'h00; valueA = cmd(sel, 1'b0, addr); valueB = '0;
        tick();
        start = 1'b0;
        if (sel == 0) begin
            check("sram_rd_not_early", done, 0);
            tick();
        end
        check($sformatf("rd_done_r%0d", sel), done, 1);
        data = result;
    endtask

    task automatic grant_and_begin(input logic [31:0] exp_addr, input int exp_size, input bit exp_rnw);
        for (int k = 0; k < 20 && !bus_request; k++) tick();
        check("bus_request", bus_request, 1);
        bus_grant = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus_begin) break;
        end
        bus_grant = 1'b0;
        check("bus_begin", bus_begin, 1);
        check("bus_address", bus_address, exp_addr);
        check("bus_burst_size", bus_burst_size, 32'(exp_size));
        check("bus_read_n_write", bus_read_n_write, 32'(exp_rnw));
    endtask

    task automatic serve_read(input logic [31:0] exp_addr, input int n, input logic [31:0] base);
        grant_and_begin(exp_addr, n - 1, 1'b1);
        tick();
        for (int i = 0; i < n; i++) begin
            bus_data_in = base + 32'(i);
            bus_data_valid_in = 1'b1;
            tick();
        end
        bus_data_valid_in = 1'b0;
        check("rd_req_dropped", bus_request, 0);
        tick();
    endtask

    task automatic serve_write(input logic [31:0] exp_addr, input int n, input int first, input int busy_at);
        grant_and_begin(exp_addr, n - 1, 1'b0);
        tick();
        for (int i = 0; i < n; i++) begin
            check("wr_valid", bus_data_valid_out, 1);
            check("wr_data", bus_data_out, 32'h5000_0000 + 32'(first + i));
            if (i == busy_at) begin
                bus_busy = 1'b1;
                tick();
                check("wr_hold1", bus_data_out, 32'h5000_0000 + 32'(first + i));
                tick();
                check("wr_hold2", bus_data_out, 32'h5000_0000 + 32'(first + i));
                bus_busy = 1'b0;
            end
            tick();
        end
        check("wr_end", bus_end_out, 1);
        check("wr_valid_off", bus_data_valid_out, 0);
        tick();
        check("wr_end_pulse", bus_end_out, 0);
    endtask

    logic [31:0] rd;

    initial begin
        reset = 1'b1; start = 1'b0; valueA = '0; valueB = '0; ciN = '0;
        bus_grant = 1'b0; bus_data_in = '0; bus_data_valid_in = 1'b0;
        bus_busy = 1'b0; bus_error = 1'b0;
        repeat (3) tick();
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_request", bus_request, 0);
        check("rst_begin", bus_begin, 0);
        reset = 1'b0;
        tick();

        // SRAM write/read with a start during the pending read cycle
        ci_write(0, 9'h1F3, 32'hDEAD_BEEF);
        start = 1'b1; valueA = cmd(0, 1'b0, 9'h1F3);
        tick();
        check("sram_rd_pending", done, 0);
        valueA = cmd(1, 1'b1, 0); valueB = 32'h1234_5678;
        tick();
        start = 1'b0;
        check("sram_rd_done", done, 1);
        check("sram_rd_data", result, 32'hDEAD_BEEF);
        tick();
        check("pending_start_ignored", done, 0);
        ci_read(1, 0, rd);
        check("reg1_unchanged", rd, 0);
        ci_read(6, 0, rd);
        check("reg6_zero", rd, 0);

        // Decode filtering
        start = 1'b1; ciN = 8'h01; valueA = cmd(5, 1'b0, 0);
        tick();
        check("wrong_ciN_no_done", done, 0);
        ciN = 8'h00; valueA = cmd(5, 1'b0, 0) | 32'h0000_2000;
        tick();
        start = 1'b0;
        check("upper_bits_no_done", done, 0);

        // Bus -> SRAM, two bursts of four
        ci_write(1, 0, 32'h0000_1003);
        ci_read(1, 0, rd);
        check("reg1_low_bits_forced", rd, 32'h0000_1000);
        ci_write(2, 0, 0);
        ci_write(3, 0, 8);
        ci_write(4, 0, 3);
        ci_write(5, 0, 1);
        ci_read(5, 0, rd);
        check("status_busy", rd, 1);
        serve_read(32'h0000_1000, 4, 32'hA000_0000);
        serve_read(32'h0000_1010, 4, 32'hA000_0004);
        ci_read(5, 0, rd);
        check("status_idle", rd, 0);
        for (int i = 0; i < 8; i++) begin
            ci_read(0, i, rd);
            check($sformatf("rd_sram_%0d", i), rd, 32'hA000_0000 + 32'(i));
        end

        // SRAM -> bus, 5 words as 4 + 1, stall mid-burst
        for (int i = 0; i < 5; i++) ci_write(0, 9'h040 + i, 32'h5000_0000 + 32'(i));
        ci_write(1, 0, 32'h0000_2000);
        ci_write(2, 0, 9'h040);
        ci_write(3, 0, 5);
        ci_write(4, 0, 3);
        ci_write(5, 0, 2);
        serve_write(32'h0000_2000, 4, 0, 1);
        serve_write(32'h0000_2010, 1, 4, -1);
        ci_read(5, 0, rd);
        check("status_after_write", rd, 0);

        // SRAM address wrap
        ci_write(1, 0, 32'h0000_3000);
        ci_write(2, 0, 510);
        ci_write(3, 0, 4);
        ci_write(5, 0, 1);
        serve_read(32'h0000_3000, 4, 32'hC000_0000);
        ci_read(0, 510, rd); check("wrap_510", rd, 32'hC000_0000);
        ci_read(0, 511, rd); check("wrap_511", rd, 32'hC000_0001);
        ci_read(0, 0, rd);   check("wrap_0", rd, 32'hC000_0002);
        ci_read(0, 1, rd);   check("wrap_1", rd, 32'hC000_0003);

        // Bus error on the third word
        ci_write(1, 0, 32'h0000_4000);
        ci_write(2, 0, 9'h100);
        ci_write(3, 0, 8);
        ci_write(4, 0, 7);
        ci_write(5, 0, 1);
        grant_and_begin(32'h0000_4000, 7, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            bus_data_in = 32'hE000_0000 + 32'(i); bus_data_valid_in = 1'b1;
            tick();
        end
        bus_error = 1'b1;
        tick();
        bus_error = 1'b0; bus_data_valid_in = 1'b0;
        check("err_request_drop", bus_request, 0);
        check("err_begin_low", bus_begin, 0);
        ci_read(5, 0, rd);
        check("status_error", rd, 32'h2);

        // Zero-size start: clears error, no bus activity
        ci_write(3, 0, 0);
        ci_write(5, 0, 1);
        check("zero_size_no_request", bus_request, 0);
        ci_read(5, 0, rd);
        check("status_error_cleared", rd, 0);

        // Reset in the middle of a burst
        ci_write(1, 0, 32'h0000_5000);
        ci_write(2, 0, 9'h020);
        ci_write(3, 0, 8);
        ci_write(4, 0, 3);
        ci_write(5, 0, 1);
        grant_and_begin(32'h0000_5000, 3, 1'b1);
        tick();
        bus_data_in = 32'hF000_0000; bus_data_valid_in = 1'b1;
        tick();
        reset = 1'b1; bus_data_valid_in = 1'b0;
        start = 1'b1; valueA = cmd(5, 1'b0, 0);
        tick();
        start = 1'b0;
        check("mid_rst_request", bus_request, 0);
        check("mid_rst_begin", bus_begin, 0);
        check("mid_rst_done", done, 0);
        reset = 1'b0;
        tick();
        ci_read(5, 0, rd); check("post_rst_status", rd, 0);
        ci_read(1, 0, rd); check("post_rst_reg1", rd, 0);
        ci_read(0, 9'h1F3, rd); check("sram_kept", rd, 32'hDEAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
